// File: rtl/rf_pkg.sv
// Shared widths and constants for the scoreboarded register file.
package rf_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned REG_ZERO  = 0;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bus of the register file; clock and reset stay outside.
interface regfile_sb_if
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned NREAD  = 2
);

    logic [NREAD*ADDR_W-1:0] raddr;
    logic [NREAD*DATA_W-1:0] rdata;
    logic [NREAD-1:0]        rbusy;
    logic                    wa_en;
    logic [ADDR_W-1:0]       wa_addr;
    logic [DATA_W-1:0]       wa_data;
    logic                    wb_en;
    logic [ADDR_W-1:0]       wb_addr;
    logic [DATA_W-1:0]       wb_data;
    logic                    sb_set;
    logic [ADDR_W-1:0]       sb_addr;
    logic                    hilo_we;
    logic [DATA_W-1:0]       hi_wdata;
    logic [DATA_W-1:0]       lo_wdata;
    logic [DATA_W-1:0]       hi_rdata;
    logic [DATA_W-1:0]       lo_rdata;
    logic                    waw_err;

    modport master (
        output raddr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               sb_set, sb_addr, hilo_we, hi_wdata, lo_wdata,
        input  rdata, rbusy, hi_rdata, lo_rdata, waw_err
    );

    modport slave (
        input  raddr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               sb_set, sb_addr, hilo_we, hi_wdata, lo_wdata,
        output rdata, rbusy, hi_rdata, lo_rdata, waw_err
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for pending multicycle results, with WAW detection.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned NREAD  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*ADDR_W-1:0] raddr,
    input  logic                    wa_en,
    input  logic [ADDR_W-1:0]       wa_addr,
    input  logic                    wb_en,
    input  logic [ADDR_W-1:0]       wb_addr,
    input  logic                    sb_set,
    input  logic [ADDR_W-1:0]       sb_addr,
    output logic [NREAD-1:0]        rbusy_c,
    output logic                    waw_err
);

    localparam int unsigned        DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0]  ZERO  = ADDR_W'(REG_ZERO);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             waw_nxt;

    // Set is applied after clear so a back-to-back issue keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (wb_en && (wb_addr != ZERO)) busy_nxt[wb_addr] = 1'b0;
        if (sb_set && (sb_addr != ZERO)) busy_nxt[sb_addr] = 1'b1;
    end

    // A same-cycle late writeback to the target resolves the hazard, so no error.
    assign waw_nxt = wa_en && (wa_addr != ZERO) && busy[wa_addr]
                     && !(wb_en && (wb_addr == wa_addr));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy    <= '0;
            waw_err <= 1'b0;
        end else begin
            busy    <= busy_nxt;
            waw_err <= waw_nxt;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rbusy
        logic [ADDR_W-1:0] ra;
        assign ra         = raddr[i*ADDR_W +: ADDR_W];
        assign rbusy_c[i] = busy[ra] && !(wb_en && (wb_addr == ra));
    end

endmodule

// File: rtl/regfile_sb.sv
// GPR file with NREAD write-first read ports, two write ports, HI/LO and a busy scoreboard.
module regfile_sb
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned NREAD  = 2
) (
    input  logic         RF_CLK,
    input  logic         reset,
    regfile_sb_if.slave  bus
);

    localparam int unsigned        DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0]  ZERO  = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              wa_hit;
    logic              wb_hit;

    assign wa_hit = bus.wa_en && (bus.wa_addr != ZERO);
    assign wb_hit = bus.wb_en && (bus.wb_addr != ZERO);

    // Port A is written last so it wins a same-index collision with port B.
    always_ff @(posedge RF_CLK or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < DEPTH; r++) regs[r] <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (wb_hit) regs[bus.wb_addr] <= bus.wb_data;
            if (wa_hit) regs[bus.wa_addr] <= bus.wa_data;
            if (bus.hilo_we) begin
                hi_q <= bus.hi_wdata;
                lo_q <= bus.lo_wdata;
            end
        end
    end

    // Entry 0 is never written, so reading it through the array yields zero.
    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [ADDR_W-1:0] ra;
        assign ra = bus.raddr[i*ADDR_W +: ADDR_W];
        assign bus.rdata[i*DATA_W +: DATA_W] =
            (wa_hit && (bus.wa_addr == ra)) ? bus.wa_data :
            (wb_hit && (bus.wb_addr == ra)) ? bus.wb_data :
                                              regs[ra];
    end

    assign bus.hi_rdata = hi_q;
    assign bus.lo_rdata = lo_q;

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREAD  (NREAD)
    ) u_sb (
        .clk     (RF_CLK),
        .reset   (reset),
        .raddr   (bus.raddr),
        .wa_en   (bus.wa_en),
        .wa_addr (bus.wa_addr),
        .wb_en   (bus.wb_en),
        .wb_addr (bus.wb_addr),
        .sb_set  (bus.sb_set),
        .sb_addr (bus.sb_addr),
        .rbusy_c (bus.rbusy),
        .waw_err (bus.waw_err)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Scenario bench for regfile_sb: expectations queued at stimulus time, popped when sampled.
module tb_regfile_sb;

    logic clk;
    logic reset;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bus ();

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) dut (
        .RF_CLK (clk),
        .reset  (reset),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int { O_RD0, O_RD1, O_RB0, O_RB1, O_WAW, O_HI, O_LO } obs_e;

    typedef struct {
        string       name;
        obs_e        sel;
        logic [31:0] exp;
    } sb_ent_t;

    sb_ent_t     sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic void want(string n, obs_e s, logic [31:0] e);
        sb_ent_t t;
        t.name = n;
        t.sel  = s;
        t.exp  = e;
        sb_q.push_back(t);
    endfunction

    function automatic logic [31:0] observe(obs_e s);
        case (s)
            O_RD0:   return bus.rdata[31:0];
            O_RD1:   return bus.rdata[63:32];
            O_RB0:   return {31'b0, bus.rbusy[0]};
            O_RB1:   return {31'b0, bus.rbusy[1]};
            O_WAW:   return {31'b0, bus.waw_err};
            O_HI:    return bus.hi_rdata;
            O_LO:    return bus.lo_rdata;
            default: return 'x;
        endcase
    endfunction

    task automatic idle;
        bus.wa_en    = 1'b0;
        bus.wa_addr  = '0;
        bus.wa_data  = '0;
        bus.wb_en    = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        bus.sb_set   = 1'b0;
        bus.sb_addr  = '0;
        bus.hilo_we  = 1'b0;
        bus.hi_wdata = '0;
        bus.lo_wdata = '0;
    endtask

    task automatic test_reset;
        sb_ent_t e;
        logic [31:0] got;
        idle();
        bus.raddr = {5'd4, 5'd5};
        reset = 1'b1;
        #2;
        want("rst_rd0", O_RD0, 32'h0);
        want("rst_rb0", O_RB0, 32'h0);
        want("rst_rb1", O_RB1, 32'h0);
        want("rst_waw", O_WAW, 32'h0);
        want("rst_hi",  O_HI,  32'h0);
        want("rst_lo",  O_LO,  32'h0);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front(); got = observe(e.sel); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.exp);
            end
        end
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_write_bypass;
        sb_ent_t e;
        logic [31:0] got;
        @(negedge clk);
        bus.wa_en = 1'b1; bus.wa_addr = 5'd5; bus.wa_data = 32'h1234;
        bus.raddr = {5'd0, 5'd5};
        #1;
        want("wa_bypass_r5", O_RD0, 32'h1234);
        want("r0_read",      O_RD1, 32'h0);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front(); got = observe(e.sel); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.exp);
            end
        end
        @(negedge clk);
        idle();
        #1;
        want("wa_stored_r5", O_RD0, 32'h1234);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front(); got = observe(e.sel); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.exp);
            end
        end
    endtask

    task automatic test_busy;
        sb_ent_t e;
        logic [31:0] got;
        @(negedge clk);
        bus.sb_set = 1'b1; bus.sb_addr = 5'd8;
        bus.raddr = {5'd8, 5'd0};
        #1;
        want("set_not_visible_r8", O_RB1, 32'h0);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front(); got = observe(e.sel); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.exp);
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            idle();
            #1;
            want($sformatf("busy_hold_r8_c%0d", c), O_RB1, 32'h1);
            while (sb_q.size() != 0) begin
                e = sb_q.pop_front(); got = observe(e.sel); n_checks++;
                if (got !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.exp);
                end
            end
        end
        @(negedge clk);
        bus.wb_en = 1'b1; bus.wb_addr = 5'd8; bus.wb_data = 32'hDEAD;
        #1;
        want("wb_rbusy_bypass_r8", O_RB1, 32'h0);
        want("wb_bypass_r8",       O_RD1, 32'hDEAD);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front(); got = observe(e.sel); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.exp);
            end
        end
        @(negedge clk);
        idle();
        #1;
        want("wb_cleared_r8", O_RB1, 32'h0);
        want("wb_stored_r8",  O_RD1, 32'hDEAD);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front(); got = observe(e.sel); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.exp);
            end
        end
    endtask

    task automatic test_collision;
        sb_ent_t e;
        logic [31:0] got;
        @(negedge clk);
        bus.sb_set = 1'b1; bus.sb_addr = 5'd3;
        bus.raddr = {5'd0, 5'd3};
        @(negedge clk);
        idle();
        bus.wa_en = 1'b1; bus.wa_addr = 5'd3; bus.wa_data = 32'h11;
        bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h22;
        #1;
        want("coll_bypass_r3", O_RD0, 32'h11);
        want("coll_rbusy_r3",  O_RB0, 32'h0);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front(); got = observe(e.sel); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.exp);
            end
        end
        @(posedge clk);
        #1;
        want("coll_no_waw", O_WAW, 32'h0);
        idle();
        #1;
        want("coll_stored_r3", O_RD0, 32'h11);
        want("coll_clear_r3",  O_RB0, 32'h0);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front(); got = observe(e.sel); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.exp);
            end
        end
    endtask

    task automatic test_set_clear;
        sb_ent_t e;
        logic [31:0] got;
        @(negedge clk);
        bus.sb_set = 1'b1; bus.sb_addr = 5'd4;
        bus.wb_en  = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'h44;
        bus.raddr  = {5'd0, 5'd4};
        @(negedge clk);
        idle();
        #1;
        want("set_wins_r4",  O_RB0, 32'h1);
        want("wb_stored_r4", O_RD0, 32'h44);
        want("no_waw_yet",   O_WAW, 32'h0);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front(); got = observe(e.sel); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.exp);
            end
        end
        bus.wa_en = 1'b1; bus.wa_addr = 5'd4; bus.wa_data = 32'h55;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            want($sformatf("waw_pulse_%0d", c), O_WAW, 32'h1);
            while (sb_q.size() != 0) begin
                e = sb_q.pop_front(); got = observe(e.sel); n_checks++;
                if (got !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.exp);
                end
            end
        end
        idle();
        @(posedge clk);
        #1;
        want("waw_drop",      O_WAW, 32'h0);
        want("wa_busy_kept",  O_RB0, 32'h1);
        want("wa_stored_r4",  O_RD0, 32'h55);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front(); got = observe(e.sel); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.exp);
            end
        end
    endtask

    task automatic test_r0;
        sb_ent_t e;
        logic [31:0] got;
        @(negedge clk);
        bus.wa_en  = 1'b1; bus.wa_addr = 5'd0; bus.wa_data = 32'hFFFF_FFFF;
        bus.wb_en  = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
        bus.sb_set = 1'b1; bus.sb_addr = 5'd0;
        bus.raddr  = {5'd0, 5'd0};
        #1;
        want("r0_no_bypass", O_RD0, 32'h0);
        want("r0_rbusy",     O_RB0, 32'h0);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front(); got = observe(e.sel); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.exp);
            end
        end
        @(posedge clk);
        #1;
        want("r0_no_waw", O_WAW, 32'h0);
        idle();
        #1;
        want("r0_stays_zero",   O_RD1, 32'h0);
        want("r0_never_busy",   O_RB1, 32'h0);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front(); got = observe(e.sel); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.exp);
            end
        end
    endtask

    task automatic test_hilo_reset;
        sb_ent_t e;
        logic [31:0] got;
        @(negedge clk);
        bus.hilo_we = 1'b1; bus.hi_wdata = 32'hA; bus.lo_wdata = 32'hB;
        bus.raddr = {5'd4, 5'd5};
        @(negedge clk);
        idle();
        #1;
        want("hi_written",   O_HI,  32'hA);
        want("lo_written",   O_LO,  32'hB);
        want("r5_pre_reset", O_RD0, 32'h1234);
        want("r4_pre_reset", O_RB1, 32'h1);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front(); got = observe(e.sel); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.exp);
            end
        end
        #1 reset = 1'b1;
        #1;
        want("async_hi",   O_HI,  32'h0);
        want("async_lo",   O_LO,  32'h0);
        want("async_r5",   O_RD0, 32'h0);
        want("async_busy", O_RB1, 32'h0);
        want("async_waw",  O_WAW, 32'h0);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front(); got = observe(e.sel); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.exp);
            end
        end
        @(negedge clk) reset = 1'b0;
        bus.wa_en = 1'b1; bus.wa_addr = 5'd6; bus.wa_data = 32'h66;
        bus.raddr = {5'd4, 5'd6};
        @(negedge clk);
        idle();
        #1;
        want("post_reset_write_r6", O_RD0, 32'h66);
        want("post_reset_r4_idle",  O_RB1, 32'h0);
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front(); got = observe(e.sel); n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%h expected 0x%h", e.name, got, e.exp);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.raddr = '0;
        idle();
        test_reset();
        test_write_bypass();
        test_busy();
        test_collision();
        test_set_clear();
        test_r0();
        test_hilo_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
